// File: rtl/ip_send_gen.sv
// IPv4 header inserter: prepends EtherType and a 20-byte IPv4 header to a byte-serial payload.
// Define IP_SEND_VLAN_EN to prepend an 802.1Q tag (0x8100 + VLAN_TCI) before the EtherType.
module ip_send_gen #(
    parameter logic [7:0]  TOS      = 8'hB8,
    parameter logic [7:0]  TTL      = 8'h80,
    parameter logic        DF       = 1'b0,
    parameter logic [15:0] ID_INIT  = 16'h0000,
    parameter logic [15:0] VLAN_TCI = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tx_enable,
    input  logic [7:0]  data_in,
    input  logic [7:0]  protocol,
    input  logic [15:0] length,
    input  logic [31:0] local_ip,
    input  logic [31:0] destination_ip,
    output logic        active,
    output logic [7:0]  data_out,
    output logic [15:0] ident,
    output logic        overrun
);

`ifdef IP_SEND_VLAN_EN
    localparam int unsigned HDR_LEN = 26;
`else
    localparam int unsigned HDR_LEN = 22 + 0 * $bits(VLAN_TCI);
`endif
    localparam int unsigned HDR_BITS = HDR_LEN * 8;
    localparam int unsigned BW       = $clog2(HDR_LEN);
    localparam logic [BW-1:0] LAST_BYTE = BW'(HDR_LEN - 1);
    localparam logic [15:0] FLAGS = {1'b0, DF, 14'b0};

    typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       byte_no_q, byte_no_d;
    logic [HDR_BITS-1:0] shreg_q, shreg_d;
    logic [15:0]         ident_q, ident_d;
    logic                overrun_q, overrun_d;

    logic [HDR_BITS-1:0] header;
    logic [15:0]         total_len;
    logic [19:0]         csum_acc;
    logic [16:0]         csum_fold1;
    logic [15:0]         csum_fold2;
    logic [15:0]         checksum;
    logic                flush_done;

    // The last flush cycle reloads the header, so it must already carry the next ident.
    always_comb begin
        flush_done = (state_q == FLUSH) && !tx_enable && (byte_no_q == '0);
        ident_d    = flush_done ? ident_q + 16'd1 : ident_q;
    end

    always_comb begin
        total_len  = length + 16'd20;
        csum_acc   = 20'({8'h45, TOS}) + 20'(total_len) + 20'(ident_d) + 20'(FLAGS)
                   + 20'({TTL, protocol})
                   + 20'(local_ip[31:16]) + 20'(local_ip[15:0])
                   + 20'(destination_ip[31:16]) + 20'(destination_ip[15:0]);
        csum_fold1 = 17'(csum_acc[15:0]) + 17'(csum_acc[19:16]);
        csum_fold2 = csum_fold1[15:0] + 16'(csum_fold1[16]);
        checksum   = ~csum_fold2;
`ifdef IP_SEND_VLAN_EN
        header = {16'h8100, VLAN_TCI, 16'h0800, 8'h45, TOS, total_len, ident_d, FLAGS,
                  TTL, protocol, checksum, local_ip, destination_ip};
`else
        header = {16'h0800, 8'h45, TOS, total_len, ident_d, FLAGS,
                  TTL, protocol, checksum, local_ip, destination_ip};
`endif
    end

    always_comb begin
        state_d   = state_q;
        byte_no_d = byte_no_q;
        shreg_d   = shreg_q;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_enable) begin
                    state_d   = SEND;
                    byte_no_d = LAST_BYTE;
                    shreg_d   = {shreg_q[HDR_BITS-9:0], data_in};
                end else begin
                    shreg_d   = header;
                end
            end
            SEND: begin
                if (tx_enable) begin
                    byte_no_d = LAST_BYTE;
                    shreg_d   = {shreg_q[HDR_BITS-9:0], data_in};
                end else begin
                    state_d   = FLUSH;
                    byte_no_d = byte_no_q - BW'(1);
                    shreg_d   = {shreg_q[HDR_BITS-9:0], 8'h00};
                end
            end
            FLUSH: begin
                // A re-raised tx_enable joins the running packet instead of starting a new header.
                if (tx_enable) begin
                    state_d   = SEND;
                    byte_no_d = LAST_BYTE;
                    shreg_d   = {shreg_q[HDR_BITS-9:0], data_in};
                    overrun_d = 1'b1;
                end else if (byte_no_q == '0) begin
                    state_d   = IDLE;
                    shreg_d   = header;
                end else begin
                    byte_no_d = byte_no_q - BW'(1);
                    shreg_d   = {shreg_q[HDR_BITS-9:0], 8'h00};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            byte_no_q <= '0;
            shreg_q   <= '0;
            ident_q   <= ID_INIT;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_no_q <= byte_no_d;
            shreg_q   <= shreg_d;
            ident_q   <= ident_d;
            overrun_q <= overrun_d;
        end
    end

    // Reset masks the registered outputs in the same cycle it is asserted.
    assign active   = tx_enable | ((state_q != IDLE) & ~reset);
    assign data_out = reset ? 8'h00 : shreg_q[HDR_BITS-1 -: 8];
    assign ident    = ident_q;
    assign overrun  = overrun_q & ~reset;

endmodule

// File: tb/tb_ip_send_gen.sv
// Directed self-checking bench for ip_send_gen; a second instance with ID_INIT=FFFF checks ident wrap.
module tb_ip_send_gen;

`ifdef IP_SEND_VLAN_EN
    localparam logic [7:0] FIRST_BYTE = 8'h81;
`else
    localparam logic [7:0] FIRST_BYTE = 8'h08;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        tx_enable;
    logic [7:0]  data_in;
    logic [7:0]  protocol;
    logic [15:0] length;
    logic [31:0] local_ip;
    logic [31:0] destination_ip;
    logic        active, active_w;
    logic [7:0]  data_out, data_out_w;
    logic [15:0] ident, ident_w;
    logic        overrun, overrun_w;

    int total = 0;
    int bad = 0;
    int act_cnt;
    int ov_cnt;
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    ip_send_gen #(.VLAN_TCI(16'h0064)) dut (
        .clock(clock), .reset(reset), .tx_enable(tx_enable), .data_in(data_in),
        .protocol(protocol), .length(length), .local_ip(local_ip),
        .destination_ip(destination_ip), .active(active), .data_out(data_out),
        .ident(ident), .overrun(overrun)
    );

    ip_send_gen #(.ID_INIT(16'hFFFF), .VLAN_TCI(16'h0064)) dut_w (
        .clock(clock), .reset(reset), .tx_enable(tx_enable), .data_in(data_in),
        .protocol(protocol), .length(length), .local_ip(local_ip),
        .destination_ip(destination_ip), .active(active_w), .data_out(data_out_w),
        .ident(ident_w), .overrun(overrun_w)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, sample mid-cycle, return just after the next rising edge.
    task automatic applyStimulus(input logic en, input logic [7:0] d);
        tx_enable = en;
        data_in   = d;
        @(negedge clock);
        if (active) begin
            act_cnt++;
            obs_q.push_back(data_out);
        end
        if (overrun) ov_cnt++;
        @(posedge clock);
        #1;
    endtask

    task automatic startCapture();
        obs_q.delete();
        exp_q.delete();
        act_cnt = 0;
        ov_cnt  = 0;
    endtask

    task automatic pushHeader(input logic [15:0] tl, input logic [15:0] id,
                              input logic [7:0] proto, input logic [15:0] ck);
`ifdef IP_SEND_VLAN_EN
        exp_q.push_back(8'h81); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h64);
`endif
        exp_q.push_back(8'h08); exp_q.push_back(8'h00);
        exp_q.push_back(8'h45); exp_q.push_back(8'hB8);
        exp_q.push_back(tl[15:8]); exp_q.push_back(tl[7:0]);
        exp_q.push_back(id[15:8]); exp_q.push_back(id[7:0]);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h80); exp_q.push_back(proto);
        exp_q.push_back(ck[15:8]); exp_q.push_back(ck[7:0]);
        exp_q.push_back(8'hC0); exp_q.push_back(8'hA8);
        exp_q.push_back(8'h01); exp_q.push_back(8'h0A);
        exp_q.push_back(8'hC0); exp_q.push_back(8'hA8);
        exp_q.push_back(8'h01); exp_q.push_back(8'h01);
    endtask

    task automatic checkStream(input string tag);
        logic [7:0] b;
        checkOutput({tag, " active_cycles"}, act_cnt, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            b = (i < obs_q.size()) ? obs_q[i] : 8'hxx;
            checkOutput($sformatf("%s byte%0d", tag, i), b, exp_q[i]);
        end
    endtask

    task automatic udpPacket(input string tag, input logic [15:0] id, input logic [15:0] ck);
        startCapture();
        pushHeader(16'h001C, id, 8'h11, ck);
        for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(i));
        repeat (30) applyStimulus(1'b0, 8'h00);
        checkStream(tag);
        checkOutput({tag, " overrun_count"}, ov_cnt, 0);
    endtask

    initial begin
        reset          = 1'b1;
        tx_enable      = 1'b0;
        data_in        = 8'h00;
        protocol       = 8'd17;
        length         = 16'd8;
        local_ip       = 32'hC0A8010A;
        destination_ip = 32'hC0A80101;
        @(posedge clock);
        #1;

        // Reset cycle: outputs forced low, active tracks tx_enable.
        @(negedge clock);
        checkOutput("reset data_out", data_out, 8'h00);
        checkOutput("reset active idle", active, 1'b0);
        checkOutput("reset overrun", overrun, 1'b0);
        tx_enable = 1'b1;
        #1;
        checkOutput("reset active follows tx", active, 1'b1);
        tx_enable = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post-reset ident", ident, 16'h0000);
        checkOutput("post-reset ident_w", ident_w, 16'hFFFF);
        checkOutput("post-reset active", active, 1'b0);
        checkOutput("post-reset data_out", data_out, 8'h00);
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("idle first byte", data_out, FIRST_BYTE);
        @(posedge clock);
        #1;

        udpPacket("pktA", 16'h0000, 16'hB6BD);
        checkOutput("pktA ident after", ident, 16'h0001);
        checkOutput("pktA ident_w wrap", ident_w, 16'h0000);

        udpPacket("pktB", 16'h0001, 16'hB6BC);
        checkOutput("pktB ident after", ident, 16'h0002);
        checkOutput("pktB ident_w after", ident_w, 16'h0001);

        // ICMP, zero-length payload, single-cycle tx_enable.
        protocol = 8'd1;
        length   = 16'd0;
        applyStimulus(1'b0, 8'h00);
        startCapture();
        pushHeader(16'h0014, 16'h0002, 8'h01, 16'hB6D3);
        exp_q.push_back(8'hAA);
        applyStimulus(1'b1, 8'hAA);
        repeat (30) applyStimulus(1'b0, 8'h00);
        checkStream("icmp");
        checkOutput("icmp ident after", ident, 16'h0003);

        // Back-to-back: tx_enable re-raised 5 cycles after falling merges into one packet.
        protocol = 8'd17;
        length   = 16'd8;
        applyStimulus(1'b0, 8'h00);
        startCapture();
        pushHeader(16'h001C, 16'h0003, 8'h11, 16'hB6BA);
        exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h13);
        repeat (5) exp_q.push_back(8'h00);
        exp_q.push_back(8'h21); exp_q.push_back(8'h22);
        applyStimulus(1'b1, 8'h11);
        applyStimulus(1'b1, 8'h12);
        applyStimulus(1'b1, 8'h13);
        repeat (5) applyStimulus(1'b0, 8'h55);
        applyStimulus(1'b1, 8'h21);
        checkOutput("b2b ident stable", ident, 16'h0003);
        applyStimulus(1'b1, 8'h22);
        repeat (30) applyStimulus(1'b0, 8'h00);
        checkStream("b2b");
        checkOutput("b2b overrun_count", ov_cnt, 1);
        checkOutput("b2b ident once", ident, 16'h0004);

        // Reset while header byte 10 is on the wire.
        startCapture();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(i + 1));
        reset     = 1'b1;
        tx_enable = 1'b1;
        @(negedge clock);
        checkOutput("midreset data_out", data_out, 8'h00);
        checkOutput("midreset active", active, 1'b1);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        tx_enable = 1'b0;
        @(negedge clock);
        checkOutput("midreset after active", active, 1'b0);
        checkOutput("midreset after data_out", data_out, 8'h00);
        checkOutput("midreset ident", ident, 16'h0000);
        checkOutput("midreset ident_w", ident_w, 16'hFFFF);
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("midreset reload", data_out, FIRST_BYTE);
        @(posedge clock);
        #1;

        udpPacket("pktR", 16'h0000, 16'hB6BD);
        checkOutput("pktR ident after", ident, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
